// File: rtl/mult_cdb_buffer.sv
// Tag/result buffer between the MULT reservation station, the pipelined 64-bit multiplier and the CDB.
// Latency: issue -> multiplier is combinational; mult_done -> cdb_req is one registered stage.
// Backpressure: credit-throttled issue (issue_ready) since the multiplier cannot stall; results wait for cdb_grant.
//
// Ports:
//   clock, reset_n                          rising-edge clock, asynchronous active-low reset
//   issue_valid/issue_ready/issue_tag/...   RS issue handshake with 64-bit operands
//   mult_start/mult_mcand/mult_mplier       start strobe and operands to the multiplier
//   mult_done/mult_product                  in-order, fixed-latency result from the multiplier
//   cdb_req/cdb_tag/cdb_value/cdb_grant     head result offered to the CDB arbiter
//   err_orphan                              sticky flag: a result arrived with no pending tag
//
// The multiplier's own reset must be driven from ~reset_n so no stale done
// can emerge after this buffer has forgotten its tags.

// Generic circular FIFO. Head is read straight from registered storage.
// Latency: a push is visible at the head one cycle later (when it lands in an empty FIFO).
// Backpressure: none internally; the owner guarantees no push while full unless popping the same cycle.
module mult_cdb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          do_pop;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop & ~empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // When full, push and pop share a slot: the old head is read this cycle
    // and the new entry overwrites it at the edge.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Zero when empty so the reset/idle head reads as all-zero.
    assign dout = empty ? '0 : mem[rd_ptr];

    no_overflow : assert property (@(posedge clock) disable iff (!reset_n)
        !(push && full && !do_pop));
endmodule

module mult_cdb_buffer #(
    parameter int TAG_W = 6,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             issue_valid,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [63:0]      issue_mcand,
    input  logic [63:0]      issue_mplier,
    output logic             issue_ready,
    output logic             mult_start,
    output logic [63:0]      mult_mcand,
    output logic [63:0]      mult_mplier,
    input  logic             mult_done,
    input  logic [63:0]      mult_product,
    output logic             cdb_req,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [63:0]      cdb_value,
    input  logic             cdb_grant,
    output logic             err_orphan
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = TAG_W + 64;

    logic             ready_en;     // holds issue_ready low until the first edge after reset
    logic [CW-1:0]    outstanding;  // tags in flight + results buffered
    logic             accept;
    logic             cdb_pop;
    logic             tag_empty;
    logic             tag_pop;
    logic [TAG_W-1:0] tag_head;
    logic             res_empty;
    logic [RW-1:0]    res_head;

    assign issue_ready = ready_en && (outstanding < CW'(DEPTH));
    assign accept      = issue_valid & issue_ready;

    assign mult_start  = accept;
    assign mult_mcand  = issue_mcand;
    assign mult_mplier = issue_mplier;

    // A done with no pending tag cannot be paired: drop it and flag.
    assign tag_pop = mult_done & ~tag_empty;

    assign cdb_req   = ~res_empty;
    assign cdb_tag   = res_head[RW-1:64];
    assign cdb_value = res_head[63:0];
    assign cdb_pop   = cdb_req & cdb_grant;

    mult_cdb_fifo #(.W(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (accept),
        .pop     (tag_pop),
        .din     (issue_tag),
        .dout    (tag_head),
        .empty   (tag_empty)
    );

    mult_cdb_fifo #(.W(RW), .DEPTH(DEPTH)) u_res_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (tag_pop),
        .pop     (cdb_pop),
        .din     ({tag_head, mult_product}),
        .dout    (res_head),
        .empty   (res_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_en    <= 1'b0;
            outstanding <= '0;
            err_orphan  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case ({accept, cdb_pop})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            if (mult_done && tag_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mult_cdb_buffer.sv
module tb_mult_cdb_buffer;
    localparam int TAG_W = 6;
    localparam int DEPTH = 8;
    localparam int LAT   = 3;

    logic             clock;
    logic             reset_n;
    logic             issue_valid;
    logic [TAG_W-1:0] issue_tag;
    logic [63:0]      issue_mcand;
    logic [63:0]      issue_mplier;
    logic             issue_ready;
    logic             mult_start;
    logic [63:0]      mult_mcand;
    logic [63:0]      mult_mplier;
    logic             mult_done;
    logic [63:0]      mult_product;
    logic             cdb_req;
    logic [TAG_W-1:0] cdb_tag;
    logic [63:0]      cdb_value;
    logic             cdb_grant;
    logic             err_orphan;

    int total = 0;
    int bad   = 0;

    mult_cdb_buffer #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .issue_valid  (issue_valid),
        .issue_tag    (issue_tag),
        .issue_mcand  (issue_mcand),
        .issue_mplier (issue_mplier),
        .issue_ready  (issue_ready),
        .mult_start   (mult_start),
        .mult_mcand   (mult_mcand),
        .mult_mplier  (mult_mplier),
        .mult_done    (mult_done),
        .mult_product (mult_product),
        .cdb_req      (cdb_req),
        .cdb_tag      (cdb_tag),
        .cdb_value    (cdb_value),
        .cdb_grant    (cdb_grant),
        .err_orphan   (err_orphan)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Fixed-latency multiplier stand-in, reset from ~reset_n.
    logic        pipe_vld [LAT];
    logic [63:0] pipe_prd [LAT];
    logic        force_done;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_prd[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= mult_start;
            pipe_prd[0] <= mult_mcand * mult_mplier;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_prd[i] <= pipe_prd[i-1];
            end
        end
    end

    assign mult_done    = pipe_vld[LAT-1] | force_done;
    assign mult_product = pipe_prd[LAT-1];

    // Reference model: ordered queues of pending tags and waiting results.
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [63:0]      val;
    } ent_t;

    ent_t tq[$];
    ent_t rq[$];
    int   m_out      = 0;
    bit   m_orphan   = 0;
    bit   m_ready_en = 0;

    always @(posedge clock or negedge reset_n) begin
        bit          acc;
        bit          pop;
        logic [63:0] p;
        ent_t        e;
        if (!reset_n) begin
            tq.delete();
            rq.delete();
            m_out      = 0;
            m_orphan   = 0;
            m_ready_en = 0;
        end else begin
            acc = issue_valid && m_ready_en && (m_out < DEPTH);
            pop = (rq.size() != 0) && cdb_grant;
            if (pop) void'(rq.pop_front());
            if (mult_done) begin
                if (tq.size() == 0) m_orphan = 1;
                else rq.push_back(tq.pop_front());
            end
            if (acc) begin
                p     = issue_mcand * issue_mplier;
                e.tag = issue_tag;
                e.val = p;
                tq.push_back(e);
            end
            m_out      = m_out + int'(acc) - int'(pop);
            m_ready_en = 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    bit   rec_pops = 0;
    ent_t pops[$];
    int   req_seen = 0;
    bit   watch_req = 0;

    always @(negedge clock) begin
        bit   exp_ready;
        ent_t e;
        exp_ready = m_ready_en && (m_out < DEPTH);
        chk("issue_ready", issue_ready, exp_ready);
        chk("mult_start", mult_start, issue_valid && exp_ready);
        chk("cdb_req", cdb_req, rq.size() != 0);
        chk("cdb_tag", cdb_tag, (rq.size() != 0) ? rq[0].tag : '0);
        chk("cdb_value", cdb_value, (rq.size() != 0) ? rq[0].val : '0);
        chk("err_orphan", err_orphan, m_orphan);
        if (mult_start) begin
            chk("mult_mcand", mult_mcand, issue_mcand);
            chk("mult_mplier", mult_mplier, issue_mplier);
        end
        if (rec_pops && cdb_req && cdb_grant) begin
            e.tag = cdb_tag;
            e.val = cdb_value;
            pops.push_back(e);
        end
        if (watch_req && cdb_req) req_seen++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit v, input int tag, input int a, input int b);
        issue_valid  = v;
        issue_tag    = TAG_W'(tag);
        issue_mcand  = 64'(a);
        issue_mplier = 64'(b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          seen;
        int          exp_tags [4];
        int          exp_vals [4];
        exp_tags = '{10, 11, 12, 13};
        exp_vals = '{2, 4, 6, 8};

        reset_n    = 1'b1;
        force_done = 1'b0;
        cdb_grant  = 1'b0;
        drive(0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_issue_ready", issue_ready, 0);
        chk("rst_cdb_req", cdb_req, 0);
        chk("rst_err_orphan", err_orphan, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
        chk("ready_before_first_edge", issue_ready, 0);
        tick();
        chk("ready_after_first_edge", issue_ready, 1);

        // Single op, grant held high: 3*7 = 21 under tag 5.
        cdb_grant = 1'b1;
        drive(1, 5, 3, 7);
        #1;
        chk("t2_start_pulse", mult_start, 1);
        tick();
        drive(0, 0, 0, 0);
        #1;
        chk("t2_start_low", mult_start, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (cdb_req) seen = 1;
        end
        chk("t2_req_seen", seen, 1);
        chk("t2_tag", cdb_tag, 5);
        chk("t2_value", cdb_value, 21);
        tick();
        chk("t2_req_dropped", cdb_req, 0);

        // Back-to-back tags 1..8 with no grant: credits run out.
        cdb_grant = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            drive(1, i, i, i + 1);
            tick();
        end
        chk("t3_ready_low", issue_ready, 0);
        drive(1, 9, 9, 10);
        #1;
        chk("t3_ninth_rejected", mult_start, 0);
        repeat (5) tick();
        chk("t3_head_tag", cdb_tag, 1);
        chk("t3_head_value", cdb_value, 2);

        // Full result FIFO: grant with a valid issue pending cannot accept.
        cdb_grant = 1'b1;
        #1;
        chk("t5_no_accept_when_full", mult_start, 0);
        tick();
        cdb_grant = 1'b0;
        #1;
        chk("t3_ready_after_grant", issue_ready, 1);
        // Accept and pop together leave the credit count unchanged.
        cdb_grant = 1'b1;
        #1;
        chk("t5_accept_with_pop", mult_start, 1);
        tick();
        drive(0, 0, 0, 0);
        cdb_grant = 1'b0;
        #1;
        chk("t5_ready_unchanged", issue_ready, 1);
        cdb_grant = 1'b1;
        repeat (20) tick();
        chk("t5_drained", cdb_req, 0);

        // Order under stall with grant toggling.
        rec_pops = 1;
        for (int i = 0; i < 24; i++) begin
            cdb_grant = i[0];
            if (i < 4) drive(1, 10 + i, i + 1, 2);
            else drive(0, 0, 0, 0);
            tick();
        end
        rec_pops  = 0;
        cdb_grant = 1'b0;
        chk("t4_pop_count", pops.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < pops.size()) begin
                chk("t4_order_tag", pops[i].tag, exp_tags[i]);
                chk("t4_order_value", pops[i].val, exp_vals[i]);
            end
        end

        // Orphan done with nothing pending.
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        #1;
        chk("t6_orphan_set", err_orphan, 1);
        chk("t6_no_req", cdb_req, 0);
        repeat (3) tick();
        chk("t6_orphan_sticky", err_orphan, 1);

        // Reset mid-stream: one result buffered, three in flight.
        for (int i = 0; i < 4; i++) begin
            drive(1, 20 + i, i + 2, 3);
            tick();
        end
        chk("t1_req_before_reset", cdb_req, 1);
        reset_n = 1'b0;
        #1;
        chk("t1_async_ready", issue_ready, 0);
        chk("t1_async_start", mult_start, 0);
        chk("t1_async_req", cdb_req, 0);
        chk("t1_async_tag", cdb_tag, 0);
        chk("t1_async_value", cdb_value, 0);
        chk("t1_async_orphan", err_orphan, 0);
        drive(0, 0, 0, 0);
        tick();
        reset_n = 1'b1;
        watch_req = 1;
        tick();
        chk("t1_ready_after_release", issue_ready, 1);
        repeat (10) tick();
        watch_req = 0;
        chk("t1_no_stale_req", req_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
